// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor. Computes d = x - y - b0 (mod 2^WIDTH) one bit per
//   clock, LSB first. It uses a single full-subtractor cell and a borrow
//   flip-flop. A start/ready/done handshake lets a controller issue operands
//   and collect the difference and the final borrow.
//
// Parameters
//   WIDTH  operand and result width in bits (>= 1)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request, sampled only while ready = 1
//   x      in   minuend, captured on an accepted start
//   y      in   subtrahend, captured on an accepted start
//   b0     in   borrow-in, captured on an accepted start
//   ready  out  high only in IDLE; a start presented now is accepted
//   done   out  one-cycle pulse, d/b_out hold the new result
//   d      out  registered difference, held until the next result
//   b_out  out  registered final borrow, held together with d
// -----------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b0,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sh;     // captured minuend; the bit in flight is at the LSB
  logic [WIDTH-1:0] y_sh;     // captured subtrahend; the bit in flight is at the LSB
  logic [WIDTH-1:0] r_sh;     // partial result; new bits enter from the MSB side
  logic             borrow;   // borrow flip-flop
  logic [CW-1:0]    cnt;      // index of the bit processed on the next edge

  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] r_next;

  // Full-subtractor cell and the next value of the result shift register.
  // NOTE: every signal assigned in always_comb gets a value on every path;
  // otherwise synthesis infers a latch.
  always_comb begin
    diff_bit    = x_sh[0] ^ y_sh[0] ^ borrow;
    borrow_next = (~x_sh[0] & y_sh[0]) | (~(x_sh[0] ^ y_sh[0]) & borrow);
    r_next             = r_sh >> 1;
    r_next[WIDTH-1]    = diff_bit;
  end

  // NOTE: sequential state uses non-blocking assignments only. All updates in
  // this block then see pre-edge values, which is what a register does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      x_sh   <= '0;
      y_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_sh   <= x;
            y_sh   <= y;
            borrow <= b0;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          x_sh   <= x_sh >> 1;
          y_sh   <= y_sh >> 1;
          r_sh   <= r_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          // After WIDTH shifts, r_next holds the whole difference with bit 0 at the LSB.
          if (cnt == LAST_BIT) begin
            d     <= r_next;
            b_out <= borrow_next;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registered state only, so there is no path from start.
  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor, the inverse arithmetic path to the ripple full-adder datapath. It computes d = x − y − b0 one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It trades latency for area and provides a start/ready/done handshake so a controller can issue operands and collect the difference and borrow-out.

## Interface
- WIDTH, 3, operand and result width in bits (≥1)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- x  input  WIDTH  minuend, captured on accepted start
- y  input  WIDTH  subtrahend, captured on accepted start
- b0  input  1  borrow-in, captured on accepted start
- ready  output  1  high only in IDLE; start accepted this cycle
- done  output  1  one-cycle pulse, result valid
- d  output  WIDTH  difference, registered, held until next result
- b_out  output  1  final borrow, registered, held with d

## Operation
- States: IDLE, RUN, DONE; 2-bit state register; bit counter of width clog2(WIDTH)+1.
- IDLE: ready=1. On start=1:
  - Capture x and y into shift registers and b0 into the borrow flip-flop.
  - Clear the counter and go to RUN.
  - start=0 stays in IDLE.
- RUN: each edge processes bit i = counter.
  - Difference bit: x[i]^y[i]^b.
  - Next borrow: (~x[i]&y[i]) | (~(x[i]^y[i])&b).
  - The difference bit shifts into the result shift register from the MSB side.
  - Counter increments.
  - On the edge that processes bit WIDTH−1, load d from the completed shift value, load b_out from the final borrow, and go to DONE.
- DONE: done=1 for exactly one cycle, ready=0, then unconditionally go to IDLE.
- start while state≠IDLE, including the DONE cycle, is ignored. Operand changes after capture have no effect.
- Arithmetic:
  - d = (x − y − b0) mod 2^WIDTH.
  - b_out = 1 iff x < y + b0 (unsigned).
  - Result must equal the 2's-complement form x + ~y + ~b0 with the carry inverted.
- d and b_out change only on the completing edge or on reset; they remain stable through IDLE.

## Timing
- Reset (async, immediate): state=IDLE, ready=1, done=0, d=0, b_out=0, counter=0, borrow flip-flop=0.
- Reset mid-RUN: operation is abandoned, no done pulse follows, and d/b_out are cleared to 0.
- Start accepted on edge E:
  - RUN during cycles E+1..E+WIDTH.
  - d/b_out are updated and done rises on edge E+WIDTH.
  - IDLE and ready=1 return on edge E+WIDTH+1.
- Start-to-done latency is WIDTH edges; issue interval is WIDTH+2 cycles minimum. Back-to-back: start held high is accepted again on the first IDLE cycle.
- ready and done are decoded from registered state, with no combinational path from start.
- WIDTH=1: a single RUN cycle, then DONE.

## Test plan
- Reset during idle, then release: ready=1, done=0, d=000, b_out=0 for WIDTH=3.
- x=011, y=001, b0=0, start one cycle: done pulses exactly 3 edges after acceptance, d=010, b_out=0, and ready=1 on the following cycle.
- x=001, y=011, b0=0: d=110, b_out=1. x=111, y=111, b0=1: d=111, b_out=1. x=000, y=000, b0=0: d=000, b_out=0.
- Pulse start again and change x/y during RUN and during DONE: no restart, result reflects the originally captured operands, and only one done pulse occurs.
- Assert rst one cycle in the middle of RUN: outputs clear immediately, no done pulse, and a subsequent x=111, y=010, b0=0 yields d=101, b_out=0.
- Exhaustive: all 128 (x, y, b0) combinations for WIDTH=3 issued back-to-back with start held high, compared against a reference model of x−y−b0; repeat with WIDTH=1 and WIDTH=8 using random operands.
